// File: rtl/debug_host_ctrl_pkg.sv
// Shared definitions for the byte-serial debug protocol: command codes,
// response lengths and the host controller state encoding.
package debug_pkg;

  localparam logic [7:0] CMD_LOAD_IM   = 8'd1;
  localparam logic [7:0] CMD_CONT      = 8'd2;
  localparam logic [7:0] CMD_STEP_MODE = 8'd3;
  localparam logic [7:0] CMD_READ_BR   = 8'd4;
  localparam logic [7:0] CMD_READ_DM   = 8'd5;
  localparam logic [7:0] CMD_READ_PC   = 8'd6;
  localparam logic [7:0] CMD_STEP      = 8'd7;

  localparam int BR_BYTES = 128;
  localparam int DM_BYTES = 128;
  localparam int PC_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_CMD  = 3'd1,
    ST_WAIT_CMD  = 3'd2,
    ST_FETCH     = 3'd3,
    ST_SEND_DATA = 3'd4,
    ST_WAIT_DATA = 3'd5,
    ST_RECV      = 3'd6,
    ST_DONE      = 3'd7
  } dbg_state_e;

  function automatic logic is_legal_cmd(input logic [7:0] cmd);
    return (cmd >= CMD_LOAD_IM) && (cmd <= CMD_STEP);
  endfunction

endpackage

// File: rtl/debug_host_ctrl_if.sv
// Command, program-source, UART and capture-buffer signals of the debug host
// controller. master is the controller's view, slave the environment's view.
interface debug_host_ctrl_if #(
  parameter int BYTE   = 8,
  parameter int NB_CNT = 9
);

  logic [BYTE-1:0]   i_cmd;
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic [BYTE-1:0]   o_prog_addr;
  logic [BYTE-1:0]   i_prog_data;
  logic [BYTE-1:0]   o_tx_data;
  logic              o_tx_start;
  logic              i_tx_done;
  logic [BYTE-1:0]   i_rx_data;
  logic              i_rx_done;
  logic              o_cap_we;
  logic [NB_CNT-1:0] o_cap_addr;
  logic [BYTE-1:0]   o_cap_data;
  logic              o_done;
  logic              o_error;

  modport master (
    input  i_cmd, i_cmd_valid, i_prog_data, i_tx_done, i_rx_data, i_rx_done,
    output o_cmd_ready, o_prog_addr, o_tx_data, o_tx_start,
    output o_cap_we, o_cap_addr, o_cap_data, o_done, o_error
  );

  modport slave (
    output i_cmd, i_cmd_valid, i_prog_data, i_tx_done, i_rx_data, i_rx_done,
    input  o_cmd_ready, o_prog_addr, o_tx_data, o_tx_start,
    input  o_cap_we, o_cap_addr, o_cap_data, o_done, o_error
  );

endinterface

// File: rtl/debug_host_ctrl_timeout_cnt.sv
// Response watchdog: counts idle clocks while enabled, restarts on load, and
// flags expiry on the clock that would complete TIMEOUT idle clocks.
module dbg_timeout_cnt #(
  parameter int TIMEOUT = 100000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] r_cnt;

  // Idle-clock counter, held at zero while loading, saturating at LAST
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expire = i_en && !i_load && (r_cnt == LAST);

endmodule

// File: rtl/debug_host_ctrl.sv
// Host-side initiator of the debug protocol: sends a command byte, streams the
// program image for LOAD_IM and captures the response bytes of read commands.
module debug_host_ctrl
  import debug_pkg::*;
#(
  parameter int BYTE       = 8,
  parameter int PROG_BYTES = 256,
  parameter int NB_CNT     = 9,
  parameter int STEP_BYTES = 260,
  parameter int TIMEOUT    = 100000
) (
  input  logic              i_clock,
  input  logic              i_reset,
  debug_host_ctrl_if.master bus
);

  localparam logic [BYTE-1:0]   LAST_ADDR = BYTE'(PROG_BYTES - 1);
  localparam logic [NB_CNT-1:0] CNT_ONE   = {{(NB_CNT-1){1'b0}}, 1'b1};

  dbg_state_e        r_state;
  dbg_state_e        w_state_nxt;
  logic              w_err_set;

  logic [BYTE-1:0]   r_cmd;
  logic [NB_CNT-1:0] r_total;
  logic [NB_CNT-1:0] r_cap_cnt;
  logic [NB_CNT-1:0] w_cap_cnt_nxt;
  logic [BYTE-1:0]   r_prog_addr;

  logic              r_cmd_ready;
  logic              r_tx_start;
  logic [BYTE-1:0]   r_tx_data;
  logic              r_cap_we;
  logic [NB_CNT-1:0] r_cap_addr;
  logic [BYTE-1:0]   r_cap_data;
  logic              r_done;
  logic              r_error;

  logic              w_accept;
  logic              w_legal;
  logic              w_cap;
  logic              w_last_prog;
  logic              w_expire;
  logic              w_to_load;
  logic              w_to_en;

  function automatic logic [NB_CNT-1:0] resp_total(input logic [BYTE-1:0] cmd);
    case (cmd)
      CMD_READ_BR: return NB_CNT'(BR_BYTES);
      CMD_READ_DM: return NB_CNT'(DM_BYTES);
      CMD_READ_PC: return NB_CNT'(PC_BYTES);
      CMD_STEP:    return NB_CNT'(STEP_BYTES);
      default:     return '0;
    endcase
  endfunction

  assign w_accept    = r_cmd_ready && bus.i_cmd_valid;
  assign w_legal     = is_legal_cmd(bus.i_cmd);
  assign w_last_prog = (r_prog_addr == LAST_ADDR);

  // Capture is armed from the command byte onwards and stops at the expected total
  assign w_cap = bus.i_rx_done
              && ((r_state == ST_WAIT_CMD) || (r_state == ST_RECV))
              && (r_cap_cnt < r_total);
  assign w_cap_cnt_nxt = w_cap ? (r_cap_cnt + CNT_ONE) : r_cap_cnt;

  assign w_to_en   = (r_state == ST_RECV);
  assign w_to_load = (r_state != ST_RECV) || bus.i_rx_done;

  dbg_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_load   (w_to_load),
    .i_en     (w_to_en),
    .o_expire (w_expire)
  );

  // FSM state register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and watchdog error decision
  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_legal ? ST_SEND_CMD : ST_DONE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND_CMD: begin
        w_state_nxt = ST_WAIT_CMD;
      end
      ST_WAIT_CMD: begin
        if (!bus.i_tx_done) begin
          w_state_nxt = ST_WAIT_CMD;
        end else if (r_cmd == CMD_LOAD_IM) begin
          w_state_nxt = ST_FETCH;
        end else if (w_cap_cnt_nxt >= r_total) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RECV;
        end
      end
      ST_FETCH: begin
        w_state_nxt = ST_SEND_DATA;
      end
      ST_SEND_DATA: begin
        w_state_nxt = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (!bus.i_tx_done) begin
          w_state_nxt = ST_WAIT_DATA;
        end else if (w_last_prog) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_RECV: begin
        if (w_cap && (w_cap_cnt_nxt == r_total)) begin
          w_state_nxt = ST_DONE;
        end else if (w_expire) begin
          w_state_nxt = ST_DONE;
          w_err_set   = 1'b1;
        end else begin
          w_state_nxt = ST_RECV;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Command latch, handshake/status outputs and transmit byte register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cmd       <= '0;
      r_total     <= '0;
      r_cmd_ready <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
    end else begin
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_done      <= (w_state_nxt == ST_DONE);
      r_tx_start  <= (w_state_nxt == ST_SEND_CMD) || (r_state == ST_SEND_DATA);
      if (w_accept) begin
        r_cmd   <= bus.i_cmd;
        r_total <= resp_total(bus.i_cmd);
        r_error <= !w_legal;
      end else begin
        r_cmd   <= r_cmd;
        r_total <= r_total;
        r_error <= r_error || w_err_set;
      end
      if (w_accept && w_legal) begin
        r_tx_data <= bus.i_cmd;
      end else if (r_state == ST_SEND_DATA) begin
        r_tx_data <= bus.i_prog_data;
      end else begin
        r_tx_data <= r_tx_data;
      end
    end
  end

  // Program address (cleared whenever the controller goes idle) and capture port
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_prog_addr <= '0;
      r_cap_cnt   <= '0;
      r_cap_we    <= 1'b0;
      r_cap_addr  <= '0;
      r_cap_data  <= '0;
    end else begin
      if (w_state_nxt == ST_IDLE) begin
        r_prog_addr <= '0;
      end else if ((r_state == ST_WAIT_DATA) && bus.i_tx_done && !w_last_prog) begin
        r_prog_addr <= r_prog_addr + {{(BYTE-1){1'b0}}, 1'b1};
      end else begin
        r_prog_addr <= r_prog_addr;
      end
      if (w_accept) begin
        r_cap_cnt <= '0;
      end else begin
        r_cap_cnt <= w_cap_cnt_nxt;
      end
      r_cap_we <= w_cap;
      if (w_cap) begin
        r_cap_addr <= r_cap_cnt;
        r_cap_data <= bus.i_rx_data;
      end else begin
        r_cap_addr <= r_cap_addr;
        r_cap_data <= r_cap_data;
      end
    end
  end

  assign bus.o_cmd_ready = r_cmd_ready;
  assign bus.o_prog_addr = r_prog_addr;
  assign bus.o_tx_data   = r_tx_data;
  assign bus.o_tx_start  = r_tx_start;
  assign bus.o_cap_we    = r_cap_we;
  assign bus.o_cap_addr  = r_cap_addr;
  assign bus.o_cap_data  = r_cap_data;
  assign bus.o_done      = r_done;
  assign bus.o_error     = r_error;

endmodule

// File: tb/tb_debug_host_ctrl.sv
// Self-checking bench for debug_host_ctrl: program ROM, UART TX/RX models and a
// command-level reference model of transmitted bytes, captures and status.
module tb_debug_host_ctrl;

  localparam int TO = 300;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_host_ctrl_if #(.BYTE(8), .NB_CNT(9)) bus ();

  debug_host_ctrl #(
    .BYTE(8), .PROG_BYTES(256), .NB_CNT(9), .STEP_BYTES(260), .TIMEOUT(TO)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  logic [7:0] cmd_d       = 8'h00;
  logic       cmd_valid_d = 1'b0;
  logic       tx_done_d   = 1'b0;
  logic       rx_done_d   = 1'b0;
  logic [7:0] rx_data_d   = 8'h00;
  logic [7:0] rom_q       = 8'h00;

  assign bus.i_cmd       = cmd_d;
  assign bus.i_cmd_valid = cmd_valid_d;
  assign bus.i_tx_done   = tx_done_d;
  assign bus.i_rx_done   = rx_done_d;
  assign bus.i_rx_data   = rx_data_d;
  assign bus.i_prog_data = rom_q ^ 8'hA5;

  always @(posedge clk) rom_q <= bus.o_prog_addr;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_rx[$];
  int  rx_first_delay = 0;
  int  rx_gap_max     = 0;
  bit  rx_en          = 1'b0;
  int  rx_gen         = 0;

  int  tx_timer = 0;
  int  seen_gen = 0;
  int  rx_idx   = 0;
  int  rx_wait  = 0;
  bit  rx_armed = 1'b0;
  bit  rx_active = 1'b0;

  // UART models: TX done 8 clocks after each start, RX plays exp_rx once armed by a TX done
  always @(negedge clk) begin
    tx_done_d = 1'b0;
    rx_done_d = 1'b0;
    if (!rst_n) begin
      tx_timer = 0;
    end else begin
      if (tx_timer > 0) begin
        tx_timer--;
        if (tx_timer == 0) tx_done_d = 1'b1;
      end
      if (bus.o_tx_start) tx_timer = 8;
    end
    if (rx_gen != seen_gen) begin
      seen_gen  = rx_gen;
      rx_idx    = 0;
      rx_armed  = 1'b1;
      rx_active = 1'b0;
    end
    if (rx_en && rx_armed && tx_done_d) begin
      rx_armed  = 1'b0;
      rx_active = 1'b1;
      rx_wait   = rx_first_delay;
    end
    if (rx_en && rx_active && (rx_idx < exp_rx.size())) begin
      if (rx_wait == 0) begin
        rx_data_d = exp_rx[rx_idx];
        rx_done_d = 1'b1;
        rx_idx++;
        rx_wait = int'($urandom_range(rx_gap_max, 0));
      end else begin
        rx_wait--;
      end
    end
  end

  logic [7:0] tx_log[$];
  int         cap_addr_log[$];
  logic [7:0] cap_data_log[$];
  int         done_cnt     = 0;
  logic       err_at_done  = 1'b0;
  int         cyc          = 0;
  int         last_cap_cyc = 0;
  int         err_rise_cyc = 0;
  logic       prev_err     = 1'b0;

  // Output monitor
  always @(negedge clk) begin
    cyc++;
    if (bus.o_tx_start) tx_log.push_back(bus.o_tx_data);
    if (bus.o_cap_we) begin
      cap_addr_log.push_back(int'(bus.o_cap_addr));
      cap_data_log.push_back(bus.o_cap_data);
      last_cap_cyc = cyc;
    end
    if (bus.o_done) begin
      done_cnt++;
      err_at_done = bus.o_error;
    end
    if (bus.o_error && !prev_err) err_rise_cyc = cyc;
    prev_err = bus.o_error;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int resp_len(input logic [7:0] c);
    case (c)
      8'd4, 8'd5: return 128;
      8'd6:       return 4;
      8'd7:       return 260;
      default:    return 0;
    endcase
  endfunction

  function automatic bit legal(input logic [7:0] c);
    return (c >= 8'd1) && (c <= 8'd7);
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] c);
    int n = 0;
    while (!bus.o_cmd_ready && n < 1000) begin step(); n++; end
    check("ready_before_cmd", {31'd0, bus.o_cmd_ready}, 32'd1);
    cmd_d = c;
    cmd_valid_d = 1'b1;
    step();
    cmd_valid_d = 1'b0;
    cmd_d = 8'h00;
  endtask

  task automatic run_cmd(input logic [7:0] c, input int first_delay, input int gap_max);
    int tx0, cap0, done0, rl, ncap, ntx, ntx_got, ncap_got, n;
    logic [7:0] k;
    logic [7:0] exp_b;
    logic exp_err;
    tx0   = tx_log.size();
    cap0  = cap_addr_log.size();
    done0 = done_cnt;
    rx_first_delay = first_delay;
    rx_gap_max     = gap_max;
    rx_en          = 1'b1;
    rx_gen++;
    issue(c);
    n = 0;
    while (done_cnt == done0 && n < 20000) begin step(); n++; end
    check($sformatf("c%0d_done_seen", c), {31'd0, done_cnt != done0}, 32'd1);
    repeat (20) step();
    rx_en = 1'b0;

    rl      = resp_len(c);
    ncap    = min2(exp_rx.size(), rl);
    ntx     = legal(c) ? ((c == 8'd1) ? 257 : 1) : 0;
    exp_err = !legal(c) || (exp_rx.size() < rl);
    ntx_got  = tx_log.size() - tx0;
    ncap_got = cap_addr_log.size() - cap0;

    check($sformatf("c%0d_tx_count", c), ntx_got, ntx);
    for (int i = 0; i < min2(ntx, ntx_got); i++) begin
      k = 8'(i - 1);
      exp_b = (i == 0) ? c : (k ^ 8'hA5);
      check($sformatf("c%0d_tx_byte%0d", c, i), {24'd0, tx_log[tx0 + i]}, {24'd0, exp_b});
    end
    check($sformatf("c%0d_cap_count", c), ncap_got, ncap);
    for (int i = 0; i < min2(ncap, ncap_got); i++) begin
      check($sformatf("c%0d_cap_addr%0d", c, i), cap_addr_log[cap0 + i], i);
      check($sformatf("c%0d_cap_data%0d", c, i), {24'd0, cap_data_log[cap0 + i]}, {24'd0, exp_rx[i]});
    end
    check($sformatf("c%0d_done_pulses", c), done_cnt - done0, 1);
    check($sformatf("c%0d_err_at_done", c), {31'd0, err_at_done}, {31'd0, exp_err});
    check($sformatf("c%0d_err_after", c), {31'd0, bus.o_error}, {31'd0, exp_err});
    check($sformatf("c%0d_ready_after", c), {31'd0, bus.o_cmd_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},     {31'd0, bus.o_cmd_ready}, 32'd1);
    check({tag, "_tx_start"},  {31'd0, bus.o_tx_start},  32'd0);
    check({tag, "_tx_data"},   {24'd0, bus.o_tx_data},   32'd0);
    check({tag, "_prog_addr"}, {24'd0, bus.o_prog_addr}, 32'd0);
    check({tag, "_cap_we"},    {31'd0, bus.o_cap_we},    32'd0);
    check({tag, "_cap_addr"},  {23'd0, bus.o_cap_addr},  32'd0);
    check({tag, "_cap_data"},  {24'd0, bus.o_cap_data},  32'd0);
    check({tag, "_done"},      {31'd0, bus.o_done},      32'd0);
    check({tag, "_error"},     {31'd0, bus.o_error},     32'd0);
  endtask

  initial begin
    int tx0, cap0, done0, n, rl, nrx;
    logic [7:0] c;

    repeat (3) step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();
    check("idle_ready", {31'd0, bus.o_cmd_ready}, 32'd1);

    exp_rx.delete();
    run_cmd(8'd1, 0, 0);

    exp_rx = '{8'h00, 8'h00, 8'h00, 8'h1C};
    run_cmd(8'd6, 3, 2);

    exp_rx.delete();
    for (int i = 0; i < 128; i++) exp_rx.push_back(8'($urandom_range(255, 0)));
    run_cmd(8'd4, 0, 3);

    exp_rx.delete();
    for (int i = 0; i < 40; i++) exp_rx.push_back(8'($urandom_range(255, 0)));
    run_cmd(8'd5, 1, 2);
    check("timeout_distance", err_rise_cyc - last_cap_cyc, TO);

    exp_rx.delete();
    run_cmd(8'd2, 0, 0);

    run_cmd(8'd9, 0, 0);

    for (int i = 0; i < 263; i++) exp_rx.push_back(8'($urandom_range(255, 0)));
    run_cmd(8'd7, 2, 2);

    for (int it = 0; it < 5; it++) begin
      c   = 8'($urandom_range(9, 2));
      rl  = resp_len(c);
      nrx = int'($urandom_range(rl + 2, (rl > 5) ? rl - 5 : 0));
      exp_rx.delete();
      for (int i = 0; i < nrx; i++) exp_rx.push_back(8'($urandom_range(255, 0)));
      run_cmd(c, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
    end

    exp_rx.delete();
    tx0   = tx_log.size();
    cap0  = cap_addr_log.size();
    done0 = done_cnt;
    issue(8'd1);
    n = 0;
    while ((tx_log.size() - tx0) < 11 && n < 2000) begin step(); n++; end
    check("rst_mid_reached", {31'd0, (tx_log.size() - tx0) >= 11}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    tx0 = tx_log.size();
    repeat (5) step();
    rst_n = 1'b1;
    repeat (10) step();
    check("rst_mid_no_tx", tx_log.size() - tx0, 0);
    check("rst_mid_no_cap", cap_addr_log.size() - cap0, 0);
    check("rst_mid_no_done", done_cnt - done0, 0);
    check("rst_mid_ready", {31'd0, bus.o_cmd_ready}, 32'd1);
    check("rst_mid_prog_addr", {24'd0, bus.o_prog_addr}, 32'd0);

    exp_rx = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_cmd(8'd6, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
